// File: rtl/card_hand_display_if.sv
// card_hand_display_if: load/clear/card request side and display/score
// result side of the card hand display. master drives cards in, slave is
// the display block.
interface card_hand_display_if #(
    parameter int NUM_SLOTS = 3
);
    localparam int CW = $clog2(NUM_SLOTS + 1);

    logic                   load;
    logic [3:0]             card;
    logic                   clear;
    logic [7*NUM_SLOTS-1:0] HEX;
    logic [CW-1:0]          count;
    logic [3:0]             score;
    logic                   full;
    logic                   err;

    modport master (
        output load, card, clear,
        input  HEX, count, score, full, err
    );

    modport slave (
        input  load, card, clear,
        output HEX, count, score, full, err
    );
endinterface

// File: rtl/card_hand_display.sv
// card_hand_display: holds up to NUM_SLOTS cards loaded one per strobe,
// drives one active-low 7-segment digit per slot, and reports the card count,
// full flag, reject pulse and baccarat score (sum of values mod 10).
// Optional macro CARD_BLINK_NEW_EN: blinks the newest card's digit with a
// half-period of BLINK_HALF cycles; when undefined every card shows steadily.

// Per-slot glyph and baccarat value lookup.
module card_hand_display_digit (
    input  logic [3:0] i_code,
    input  logic       i_blank,
    output logic [6:0] o_seg,
    output logic [3:0] o_val
);
    // Decode slot code to segments and point value; 0/14/15 show blank
    always_comb begin
        o_seg = 7'b1111111;
        o_val = 4'd0;
        case (i_code)
            4'd1:    begin o_seg = 7'b0001000; o_val = 4'd1; end
            4'd2:    begin o_seg = 7'b0100100; o_val = 4'd2; end
            4'd3:    begin o_seg = 7'b0110000; o_val = 4'd3; end
            4'd4:    begin o_seg = 7'b0011001; o_val = 4'd4; end
            4'd5:    begin o_seg = 7'b0010010; o_val = 4'd5; end
            4'd6:    begin o_seg = 7'b0000010; o_val = 4'd6; end
            4'd7:    begin o_seg = 7'b1111000; o_val = 4'd7; end
            4'd8:    begin o_seg = 7'b0000000; o_val = 4'd8; end
            4'd9:    begin o_seg = 7'b0010000; o_val = 4'd9; end
            4'd10:   o_seg = 7'b1000000;
            4'd11:   o_seg = 7'b1100001;
            4'd12:   o_seg = 7'b0011000;
            4'd13:   o_seg = 7'b0001001;
            default: o_seg = 7'b1111111;
        endcase
        if (i_blank) o_seg = 7'b1111111;
    end
endmodule

module card_hand_display #(
    parameter int NUM_SLOTS  = 3,
    parameter int BLINK_HALF = 2
) (
    input  logic                 slow_clock,
    input  logic                 reset,
    card_hand_display_if.slave   bus
);
    localparam int CW = $clog2(NUM_SLOTS + 1);
    localparam int SW = $clog2(9 * NUM_SLOTS + 1);

    logic [NUM_SLOTS-1:0][3:0] r_slot;
    logic [CW-1:0]             r_count;
    logic                      r_err;

    logic                      w_valid_code;
    logic                      w_full;
    logic                      w_accept;
    logic                      w_reject;
    logic [NUM_SLOTS-1:0]      w_blank;
    logic [NUM_SLOTS-1:0][6:0] w_seg;
    logic [NUM_SLOTS-1:0][3:0] w_val;
    logic [SW-1:0]             w_sum;

    assign w_valid_code = (bus.card >= 4'd1) && (bus.card <= 4'd13);
    assign w_full       = (r_count == CW'(NUM_SLOTS));
    // clear swallows a simultaneous load without flagging it
    assign w_accept     = bus.load && !bus.clear && w_valid_code && !w_full;
    assign w_reject     = bus.load && !bus.clear && (!w_valid_code || w_full);

    // Hand storage: append to slot[count], clear empties, reject pulses err
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            r_slot  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (bus.clear) begin
            r_slot  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                for (int i = 0; i < NUM_SLOTS; i++)
                    if (r_count == CW'(i)) r_slot[i] <= bus.card;
                r_count <= r_count + CW'(1);
            end
        end
    end

`ifdef CARD_BLINK_NEW_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;     // 1 = newest digit visible

    // Blink timer; restarts visible on every accepted load or clear so the
    // fresh card is never hidden in its first displayed cycle
    always_ff @(posedge slow_clock) begin
        if (reset || (!reset && (bus.clear || w_accept))) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    // Only slot[count-1] blinks; count==0 matches no slot
    always_comb begin
        w_blank = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            w_blank[i] = !r_phase && (r_count == CW'(i + 1));
    end
`else
    assign w_blank = '0;
`endif

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        card_hand_display_digit u_digit (
            .i_code  (r_slot[g]),
            .i_blank (w_blank[g]),
            .o_seg   (w_seg[g]),
            .o_val   (w_val[g])
        );
    end

    // Hand total; SW bits hold an all-nines hand
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            w_sum = w_sum + SW'(w_val[i]);
    end

    assign bus.HEX   = w_seg;
    assign bus.count = r_count;
    assign bus.score = 4'(w_sum % SW'(10));
    assign bus.full  = w_full;
    assign bus.err   = r_err;
endmodule

// File: tb/tb_card_hand_display.sv
// tb_card_hand_display: directed card sequences; each step queues the
// hand-computed display state for the cycle after its edge, and a monitor
// compares the DUT outputs against the queue head on the falling edge.
module tb_card_hand_display;
    localparam int NS = 3;
    localparam int CW = $clog2(NS + 1);

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SK = 7'b0001001;

    typedef struct {
        int              cyc;
        string           name;
        logic [7*NS-1:0] hex;
        logic [CW-1:0]   cnt;
        logic [3:0]      score;
        logic            full;
        logic            err;
    } exp_t;

    logic slow_clock = 1'b0;
    logic reset      = 1'b1;
    int   cyc        = 0;
    int   errors     = 0;
    int   checks     = 0;
    exp_t q[$];

    card_hand_display_if #(.NUM_SLOTS(NS)) bus ();

    card_hand_display #(.NUM_SLOTS(NS), .BLINK_HALF(2)) dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 slow_clock = ~slow_clock;
    always @(posedge slow_clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare every entry due this cycle; anything overdue is a miss
    always @(negedge slow_clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed actual_cycle=%0d required_cycle=%0d", e.name, cyc, e.cyc);
            end else begin
                chk(e.name, "HEX",   32'(bus.HEX),   32'(e.hex));
                chk(e.name, "count", 32'(bus.count), 32'(e.cnt));
                chk(e.name, "score", 32'(bus.score), 32'(e.score));
                chk(e.name, "full",  32'(bus.full),  32'(e.full));
                chk(e.name, "err",   32'(bus.err),   32'(e.err));
            end
        end
    end

    // Drive one cycle of inputs (called just after a rising edge) and queue
    // the state expected once the next edge has been taken
    task automatic step(input string nm, input logic ld, input logic [3:0] cd, input logic cl,
                        input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0,
                        input int cnt, input int sc, input logic fu, input logic er);
        exp_t e;
        bus.load  = ld;
        bus.card  = cd;
        bus.clear = cl;
        e.cyc   = cyc + 1;
        e.name  = nm;
        e.hex   = {d2, d1, d0};
        e.cnt   = CW'(cnt);
        e.score = 4'(sc);
        e.full  = fu;
        e.err   = er;
        q.push_back(e);
        @(posedge slow_clock);
        #1;
    endtask

    // Newest-digit glyph for blink steps: blank in the off phase when enabled
    function automatic logic [6:0] bk(input logic [6:0] g);
`ifdef CARD_BLINK_NEW_EN
        return BL;
`else
        return g;
`endif
    endfunction

    initial begin
        bus.load  = 1'b0;
        bus.card  = 4'd0;
        bus.clear = 1'b0;
        @(posedge slow_clock);
        #1;
        step("reset0", 0, 4'd0, 0, BL, BL, BL, 0, 0, 0, 0);
        step("reset1", 0, 4'd0, 0, BL, BL, BL, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++)
            step("idle", 0, 4'd0, 0, BL, BL, BL, 0, 0, 0, 0);

        step("load7",  1, 4'd7,  0, BL, BL, S7, 1, 7, 0, 0);
        step("loadK",  1, 4'd13, 0, BL, SK, S7, 2, 7, 0, 0);
        step("load5",  1, 4'd5,  0, S5, SK, S7, 3, 2, 1, 0);
        step("fullA",  1, 4'd1,  0, S5, SK, S7, 3, 2, 1, 1);
        step("clr1",   0, 4'd0,  1, BL, BL, BL, 0, 0, 0, 0);

        step("bad0",   1, 4'd0,  0, BL, BL, BL, 0, 0, 0, 1);
        step("bad15",  1, 4'd15, 0, BL, BL, BL, 0, 0, 0, 1);
        step("badend", 0, 4'd0,  0, BL, BL, BL, 0, 0, 0, 0);

        step("load9a", 1, 4'd9,  0, BL, BL, S9, 1, 9, 0, 0);
        step("load9b", 1, 4'd9,  0, BL, S9, S9, 2, 8, 0, 0);
        step("clrld",  1, 4'd4,  1, BL, BL, BL, 0, 0, 0, 0);
        step("clridl", 0, 4'd0,  0, BL, BL, BL, 0, 0, 0, 0);

        step("blink8", 1, 4'd8,  0, BL, BL, S8,     1, 8, 0, 0);
        step("on8b",   0, 4'd0,  0, BL, BL, S8,     1, 8, 0, 0);
        step("off8a",  0, 4'd0,  0, BL, BL, bk(S8), 1, 8, 0, 0);
        step("off8b",  0, 4'd0,  0, BL, BL, bk(S8), 1, 8, 0, 0);
        step("on8c",   0, 4'd0,  0, BL, BL, S8,     1, 8, 0, 0);
        step("on8d",   0, 4'd0,  0, BL, BL, S8,     1, 8, 0, 0);
        step("off8c",  0, 4'd0,  0, BL, BL, bk(S8), 1, 8, 0, 0);

        step("load3",  1, 4'd3,  0, BL, S3,     S8, 2, 1, 0, 0);
        step("on3b",   0, 4'd0,  0, BL, S3,     S8, 2, 1, 0, 0);
        step("off3a",  0, 4'd0,  0, BL, bk(S3), S8, 2, 1, 0, 0);
        step("off3b",  0, 4'd0,  0, BL, bk(S3), S8, 2, 1, 0, 0);
        step("on3c",   0, 4'd0,  0, BL, S3,     S8, 2, 1, 0, 0);
        step("bad14",  1, 4'd14, 0, BL, S3,     S8, 2, 1, 0, 1);

        bus.load = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(posedge slow_clock);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual_pending=%0d required_pending=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
